// File: rtl/arq_pkg.sv
// Shared constants for the ACL TX scheduler / ARQ source.
// Holds payload-source codes, the pktype codes the scheduler injects itself,
// and the scheduler FSM state encoding. No ports.
package arq_pkg;

    // Payload source handed to the assembler
    localparam logic [1:0] SRC_NEW     = 2'd0;
    localparam logic [1:0] SRC_OLD     = 2'd1;
    localparam logic [1:0] SRC_ZEROLEN = 2'd2;
    localparam logic [1:0] SRC_NONE    = 2'd3;

    // Packet types generated by the scheduler rather than taken from a buffer
    localparam logic [3:0] PKT_NULL = 4'h0;
    localparam logic [3:0] PKT_POLL = 4'h1;
    localparam logic [3:0] PKT_DM1  = 4'h3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_TXW,
        ST_RXW,
        ST_UPD
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping at N.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  search start index
//   gnt  out N   one-hot grant (all zero when nothing requests)
//   idx  out IW  index of the granted bit
//   any  out 1   at least one request present
module rr_pick #(
    parameter int N  = 7,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin : pick
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[IW'(j)]) begin
                any          = 1'b1;
                idx          = IW'(j);
                gnt[IW'(j)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acl_txarq_sched.sv
// Master-side ACL TX slot scheduler with per-link ARQ source state.
// Each master TX slot grants one link (data first, then POLL when the
// link's poll counter has saturated), chooses NEW/OLD/ZEROLEN payload and
// SEQN, then folds the returned ARQN/FLOW back into that link's state.
// Ports:
//   clk_6M, rstz                 clock, async active-low reset
//   link_en/txq_nonempty/flushcmd per-link status from the TX buffers
//   txq_pktype                   per-link head pktype, 4 bits per link
//   tx_slot_p/tx_done_p          slot start / packet sent pulses
//   rx_hdr_p, rx_hdr_ok, rx_lt_addr, rx_arqn, rx_flow, rx_timeout_p
//                                response header from the receiver
//   sched_vld, sel_*             grant pulse and packet selection
//   buf_pop, buf_pop_lt          release of an acknowledged payload
module acl_txarq_sched
    import arq_pkg::*;
#(
    parameter int NLINK     = 7,
    parameter int POLL_INTV = 16
) (
    input  logic               clk_6M,
    input  logic               rstz,
    input  logic [NLINK-1:0]   link_en,
    input  logic [NLINK-1:0]   txq_nonempty,
    input  logic [4*NLINK-1:0] txq_pktype,
    input  logic [NLINK-1:0]   flushcmd,
    input  logic               tx_slot_p,
    input  logic               tx_done_p,
    input  logic               rx_hdr_p,
    input  logic               rx_hdr_ok,
    input  logic [2:0]         rx_lt_addr,
    input  logic               rx_arqn,
    input  logic               rx_flow,
    input  logic               rx_timeout_p,
    output logic               sched_vld,
    output logic [2:0]         sel_lt_addr,
    output logic [3:0]         sel_pktype,
    output logic               sel_seqn,
    output logic [1:0]         sel_src,
    output logic               buf_pop,
    output logic [2:0]         buf_pop_lt
);

    localparam int IW = $clog2(NLINK);
    localparam int CW = $clog2(POLL_INTV + 1);

    sched_state_t state;

    logic [NLINK-1:0]          seqn, outstanding, stop;
    logic [NLINK-1:0][CW-1:0]  poll_cnt;
    logic [NLINK-1:0]          poll_full;
    logic [NLINK-1:0][3:0]     pkt_arr;
    logic [NLINK-1:0]          d_req, p_req, d_gnt, p_gnt, g_oh;
    logic [IW-1:0]             rr_ptr, cur_idx, d_idx, p_idx, g_idx;
    logic                      d_any, p_any, g_any;
    logic                      cur_data, killed;
    logic                      rsp_ok, rsp_arqn, rsp_flow;

    assign pkt_arr = txq_pktype;

    always_comb begin
        for (int i = 0; i < NLINK; i++)
            poll_full[i] = (poll_cnt[i] == CW'(POLL_INTV));
    end

    // A stopped link still counts as data-eligible only once FLOW reopens it.
    assign d_req = link_en & ~stop & (txq_nonempty | outstanding);
    assign p_req = link_en & poll_full;

    rr_pick #(.N(NLINK), .IW(IW)) u_pick_data (
        .req(d_req), .ptr(rr_ptr), .gnt(d_gnt), .idx(d_idx), .any(d_any)
    );
    rr_pick #(.N(NLINK), .IW(IW)) u_pick_poll (
        .req(p_req), .ptr(rr_ptr), .gnt(p_gnt), .idx(p_idx), .any(p_any)
    );

    assign g_any = d_any | p_any;
    assign g_idx = d_any ? d_idx : p_idx;
    assign g_oh  = d_any ? d_gnt : p_gnt;

    // Poll counters: any grant or a disabled link restarts the interval.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            poll_cnt <= '0;
        end else begin
            for (int i = 0; i < NLINK; i++) begin
                if (!link_en[i] || (state == ST_ARB && g_oh[i]))
                    poll_cnt[i] <= '0;
                else if (tx_slot_p && !poll_full[i])
                    poll_cnt[i] <= poll_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state       <= ST_IDLE;
            sched_vld   <= 1'b0;
            sel_lt_addr <= '0;
            sel_pktype  <= PKT_NULL;
            sel_seqn    <= 1'b0;
            sel_src     <= SRC_NEW;
            buf_pop     <= 1'b0;
            buf_pop_lt  <= '0;
            seqn        <= '0;
            outstanding <= '0;
            stop        <= '0;
            rr_ptr      <= '0;
            cur_idx     <= '0;
            cur_data    <= 1'b0;
            killed      <= 1'b0;
            rsp_ok      <= 1'b0;
            rsp_arqn    <= 1'b0;
            rsp_flow    <= 1'b0;
        end else begin
            sched_vld <= 1'b0;
            buf_pop   <= 1'b0;
            case (state)
                ST_IDLE: if (tx_slot_p) state <= ST_ARB;
                ST_ARB: begin
                    if (g_any) begin
                        state       <= ST_TXW;
                        sched_vld   <= 1'b1;
                        sel_lt_addr <= 3'(g_idx) + 3'd1;
                        sel_seqn    <= seqn[g_idx];
                        cur_idx     <= g_idx;
                        cur_data    <= d_any;
                        killed      <= 1'b0;
                        rr_ptr      <= (g_idx == IW'(NLINK - 1)) ? '0 : g_idx + 1'b1;
                        if (!d_any) begin
                            sel_src    <= SRC_NONE;
                            sel_pktype <= PKT_POLL;
                        end else if (!outstanding[g_idx]) begin
                            sel_src              <= SRC_NEW;
                            sel_pktype           <= pkt_arr[g_idx];
                            outstanding[g_idx]   <= 1'b1;
                        end else if (flushcmd[g_idx]) begin
                            // Flushed payload still needs a SEQN slot: send empty DM1.
                            sel_src    <= SRC_ZEROLEN;
                            sel_pktype <= PKT_DM1;
                        end else begin
                            sel_src    <= SRC_OLD;
                            sel_pktype <= pkt_arr[g_idx];
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_TXW: if (tx_done_p) state <= ST_RXW;
                ST_RXW: begin
                    if (rx_hdr_p || rx_timeout_p) begin
                        rsp_ok   <= rx_hdr_p && rx_hdr_ok && (rx_lt_addr == sel_lt_addr);
                        rsp_arqn <= rx_arqn;
                        rsp_flow <= rx_flow;
                        state    <= ST_UPD;
                    end
                end
                ST_UPD: begin
                    state <= ST_IDLE;
                    if (rsp_ok && !killed && link_en[cur_idx]) begin
                        stop[cur_idx] <= !rsp_flow;
                        if (cur_data && rsp_arqn) begin
                            outstanding[cur_idx] <= 1'b0;
                            seqn[cur_idx]        <= ~seqn[cur_idx];
                            buf_pop              <= 1'b1;
                            buf_pop_lt           <= sel_lt_addr;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A link dropped mid-grant lets the exchange finish but never pops.
            if ((state == ST_TXW || state == ST_RXW) && !link_en[cur_idx])
                killed <= 1'b1;

            // Disconnected links lose all ARQ state; last assignment wins.
            for (int i = 0; i < NLINK; i++) begin
                if (!link_en[i]) begin
                    seqn[i]        <= 1'b0;
                    outstanding[i] <= 1'b0;
                    stop[i]        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_acl_txarq_sched.sv
// Self-checking bench for acl_txarq_sched: a per-slot behavioural model of
// the scheduler rules predicts each grant and pop; directed scenarios are
// followed by a randomized run.
module tb_acl_txarq_sched;

    localparam int NL = 7;
    localparam int PI = 16;
    localparam logic [1:0] S_NEW = 2'd0, S_OLD = 2'd1, S_ZL = 2'd2, S_NONE = 2'd3;

    logic              clk_6M = 1'b0;
    logic              rstz = 1'b0;
    logic [NL-1:0]     link_en = '0, txq_nonempty = '0, flushcmd = '0;
    logic [NL-1:0][3:0] pk = '0;
    logic              tx_slot_p = 0, tx_done_p = 0, rx_hdr_p = 0, rx_hdr_ok = 0;
    logic [2:0]        rx_lt_addr = '0;
    logic              rx_arqn = 0, rx_flow = 0, rx_timeout_p = 0;
    logic              sched_vld, sel_seqn, buf_pop;
    logic [2:0]        sel_lt_addr, buf_pop_lt;
    logic [3:0]        sel_pktype;
    logic [1:0]        sel_src;

    acl_txarq_sched #(.NLINK(NL), .POLL_INTV(PI)) dut (
        .clk_6M(clk_6M), .rstz(rstz), .link_en(link_en), .txq_nonempty(txq_nonempty),
        .txq_pktype(pk), .flushcmd(flushcmd), .tx_slot_p(tx_slot_p), .tx_done_p(tx_done_p),
        .rx_hdr_p(rx_hdr_p), .rx_hdr_ok(rx_hdr_ok), .rx_lt_addr(rx_lt_addr), .rx_arqn(rx_arqn),
        .rx_flow(rx_flow), .rx_timeout_p(rx_timeout_p), .sched_vld(sched_vld),
        .sel_lt_addr(sel_lt_addr), .sel_pktype(sel_pktype), .sel_seqn(sel_seqn),
        .sel_src(sel_src), .buf_pop(buf_pop), .buf_pop_lt(buf_pop_lt)
    );

    always #5 clk_6M = ~clk_6M;

    int n_chk = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    bit m_seqn[NL], m_out[NL], m_stop[NL];
    int m_poll[NL];
    int m_ptr;

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) begin
            m_seqn[i] = 0; m_out[i] = 0; m_stop[i] = 0; m_poll[i] = 0;
        end
        m_ptr = 0;
    endfunction

    // kind: 0 good header, 1 timeout, 2 bad HEC, 3 wrong LT_ADDR, 4 reset in RXW
    // result: {vld, lt[2:0], pktype[3:0], seqn, src[1:0], pop, pop_lt[2:0]}
    function automatic logic [14:0] model_slot(input int kind, input bit arqn, input bit flow);
        int g, j;
        bit data, sq, pop;
        logic [3:0] p;
        logic [1:0] s;
        g = -1; data = 0; pop = 0;
        for (int i = 0; i < NL; i++) begin
            if (!link_en[i]) begin
                m_seqn[i] = 0; m_out[i] = 0; m_stop[i] = 0; m_poll[i] = 0;
            end else if (m_poll[i] < PI) begin
                m_poll[i]++;
            end
        end
        for (int k = 0; k < NL; k++) begin
            j = (m_ptr + k) % NL;
            if (g < 0 && link_en[j] && !m_stop[j] && (txq_nonempty[j] || m_out[j])) begin
                g = j; data = 1;
            end
        end
        for (int k = 0; k < NL; k++) begin
            j = (m_ptr + k) % NL;
            if (g < 0 && link_en[j] && m_poll[j] == PI) g = j;
        end
        if (g < 0) return '0;
        m_poll[g] = 0;
        m_ptr = (g + 1) % NL;
        sq = m_seqn[g];
        if (!data) begin p = 4'h1; s = S_NONE; end
        else if (!m_out[g]) begin p = pk[g]; s = S_NEW; m_out[g] = 1; end
        else if (flushcmd[g]) begin p = 4'h3; s = S_ZL; end
        else begin p = pk[g]; s = S_OLD; end
        if (kind == 4) begin
            model_reset();
        end else if (kind == 0) begin
            m_stop[g] = !flow;
            if (data && arqn) begin
                m_out[g] = 0; m_seqn[g] = !m_seqn[g]; pop = 1;
            end
        end
        return {1'b1, 3'(g + 1), p, sq, s, pop, pop ? 3'(g + 1) : 3'd0};
    endfunction

    // ---------------- slot driver (observes only) ----------------
    task automatic run_slot(input int kind, input bit arqn, input bit flow,
                            input logic [2:0] lt, output logic [14:0] got);
        logic vld, gsq, pop;
        logic [2:0] glt, plt;
        logic [3:0] gpk;
        logic [1:0] gsrc;
        vld = 0; gsq = 0; pop = 0; glt = 0; plt = 0; gpk = 0; gsrc = 0;
        @(negedge clk_6M) tx_slot_p = 1;
        @(negedge clk_6M) tx_slot_p = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_6M);
            if (sched_vld === 1'b1 && !vld) begin
                vld = 1; glt = sel_lt_addr; gpk = sel_pktype; gsq = sel_seqn; gsrc = sel_src;
            end
        end
        if (vld) begin
            @(negedge clk_6M) tx_done_p = 1;
            @(negedge clk_6M);
            tx_done_p = 0;
            case (kind)
                1: rx_timeout_p = 1;
                4: rstz = 0;
                default: begin
                    rx_hdr_p   = 1;
                    rx_hdr_ok  = (kind != 2);
                    rx_lt_addr = (kind == 3) ? ((lt == 3'd7) ? 3'd1 : lt + 3'd1) : lt;
                    rx_arqn    = arqn;
                    rx_flow    = flow;
                end
            endcase
            @(negedge clk_6M);
            rx_hdr_p = 0; rx_timeout_p = 0; rx_hdr_ok = 0; rstz = 1;
            repeat (3) begin
                @(negedge clk_6M);
                if (buf_pop === 1'b1) begin pop = 1; plt = buf_pop_lt; end
            end
        end
        got = {vld, glt, gpk, gsq, gsrc, pop, plt};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [15:0] o;
        repeat (3) @(negedge clk_6M);
        o = {sched_vld, sel_lt_addr, sel_pktype, sel_seqn, sel_src, buf_pop, buf_pop_lt};
        n_chk++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_hold got=%h exp=0", o); end
        rstz = 1;
        model_reset();
        repeat (2) @(negedge clk_6M);
        o = {sched_vld, sel_lt_addr, sel_pktype, sel_seqn, sel_src, buf_pop, buf_pop_lt};
        n_chk++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_release got=%h exp=0", o); end
    endtask

    task automatic test_ack_basic();
        logic [14:0] e, g;
        link_en = 7'b0000001; txq_nonempty = 7'b0000001; pk[0] = 4'h4; flushcmd = '0;
        for (int n = 0; n < 2; n++) begin
            e = model_slot(0, 1, 1); run_slot(0, 1, 1, e[13:11], g);
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL ack_basic slot%0d got=%h exp=%h", n, g, e); end
        end
    endtask

    task automatic test_nak_retx();
        logic [14:0] e, g;
        bit an[4] = '{0, 0, 1, 1};
        link_en = 7'b0000010; txq_nonempty = 7'b0000010; pk[1] = 4'ha;
        for (int n = 0; n < 4; n++) begin
            e = model_slot(0, an[n], 1); run_slot(0, an[n], 1, e[13:11], g);
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL nak_retx slot%0d got=%h exp=%h", n, g, e); end
        end
    endtask

    task automatic test_alternate();
        logic [14:0] e, g;
        link_en = 7'b1000101; txq_nonempty = 7'b1000101;
        pk[0] = 4'h4; pk[2] = 4'hb; pk[6] = 4'he;
        for (int n = 0; n < 7; n++) begin
            e = model_slot(0, 1, 1); run_slot(0, 1, 1, e[13:11], g);
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL alternate slot%0d got=%h exp=%h", n, g, e); end
        end
        link_en = 7'b0000101; txq_nonempty = 7'b0000101;
        for (int n = 0; n < 4; n++) begin
            e = model_slot(0, 1, 1); run_slot(0, 1, 1, e[13:11], g);
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL alternate13 slot%0d got=%h exp=%h", n, g, e); end
        end
    endtask

    task automatic test_flow_stop();
        logic [14:0] e, g;
        link_en = 7'b0000001; txq_nonempty = 7'b0000001; pk[0] = 4'h4;
        for (int n = 0; n < 18; n++) begin
            e = model_slot(0, n != 0, n != 0); run_slot(0, n != 0, n != 0, e[13:11], g);
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL flow_stop slot%0d got=%h exp=%h", n, g, e); end
        end
    endtask

    task automatic test_flush();
        logic [14:0] e, g;
        link_en = 7'b0000001; txq_nonempty = 7'b0000001; pk[0] = 4'hf;
        for (int n = 0; n < 3; n++) begin
            flushcmd = (n == 1) ? 7'b0000001 : 7'b0;
            e = model_slot(0, n != 0, 1); run_slot(0, n != 0, 1, e[13:11], g);
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL flush slot%0d got=%h exp=%h", n, g, e); end
        end
        flushcmd = '0;
    endtask

    task automatic test_bad_response();
        logic [14:0] e, g;
        int kd[4] = '{1, 3, 2, 0};
        link_en = 7'b0000100; txq_nonempty = 7'b0000100; pk[2] = 4'h8;
        for (int n = 0; n < 4; n++) begin
            e = model_slot(kd[n], 1, 1); run_slot(kd[n], 1, 1, e[13:11], g);
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL bad_rsp kind%0d got=%h exp=%h", kd[n], g, e); end
        end
    endtask

    task automatic test_reset_rxw();
        logic [14:0] e, g;
        logic [15:0] o;
        link_en = 7'b0001000; txq_nonempty = 7'b0001000; pk[3] = 4'h4;
        e = model_slot(0, 1, 1); run_slot(0, 1, 1, e[13:11], g);
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL rst_rxw pre got=%h exp=%h", g, e); end
        e = model_slot(4, 1, 1); run_slot(4, 1, 1, e[13:11], g);
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL rst_rxw slot got=%h exp=%h", g, e); end
        o = {sched_vld, sel_lt_addr, sel_pktype, sel_seqn, sel_src, buf_pop, buf_pop_lt};
        n_chk++;
        if (o !== '0) begin n_fail++; $display("FAIL rst_rxw outputs got=%h exp=0", o); end
        e = model_slot(0, 1, 1); run_slot(0, 1, 1, e[13:11], g);
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL rst_rxw post got=%h exp=%h", g, e); end
    endtask

    task automatic test_random();
        logic [14:0] e, g;
        int kind;
        bit an, fl;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NL; i++) begin
                link_en[i]      = ($urandom_range(0, 3) != 0);
                txq_nonempty[i] = $urandom_range(0, 1);
                flushcmd[i]     = ($urandom_range(0, 3) == 0);
                pk[i]           = 4'($urandom_range(4, 15));
            end
            kind = $urandom_range(0, 3);
            an   = $urandom_range(0, 1);
            fl   = ($urandom_range(0, 4) != 0);
            e = model_slot(kind, an, fl); run_slot(kind, an, fl, e[13:11], g);
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL random slot%0d got=%h exp=%h", n, g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_ack_basic();
        test_nak_retx();
        test_alternate();
        test_flow_stop();
        test_flush();
        test_bad_response();
        test_reset_rxw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
